// File: rtl/arm_dp_pkg.sv
// Shared types and constants for the ARM data-processing control path:
// FSM encoding, condition codes, ARM opcodes, ALU operation codes and
// the opcode-class helpers used by the sequencer.
package arm_dp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COND = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Condition field INSTR[31:28]
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Data-processing opcode field INSTR[24:21]
  localparam logic [3:0] OPC_AND = 4'h0;
  localparam logic [3:0] OPC_EOR = 4'h1;
  localparam logic [3:0] OPC_SUB = 4'h2;
  localparam logic [3:0] OPC_RSB = 4'h3;
  localparam logic [3:0] OPC_ADD = 4'h4;
  localparam logic [3:0] OPC_ADC = 4'h5;
  localparam logic [3:0] OPC_SBC = 4'h6;
  localparam logic [3:0] OPC_RSC = 4'h7;
  localparam logic [3:0] OPC_TST = 4'h8;
  localparam logic [3:0] OPC_TEQ = 4'h9;
  localparam logic [3:0] OPC_CMP = 4'hA;
  localparam logic [3:0] OPC_CMN = 4'hB;
  localparam logic [3:0] OPC_ORR = 4'hC;
  localparam logic [3:0] OPC_MOV = 4'hD;
  localparam logic [3:0] OPC_BIC = 4'hE;
  localparam logic [3:0] OPC_MVN = 4'hF;

  // ALU operation codes: the ARM opcode zero-extended, except MOV
  localparam logic [4:0] ALU_AND   = 5'b00000;
  localparam logic [4:0] ALU_ADD   = 5'b00100;
  localparam logic [4:0] ALU_CMP   = 5'b01010;
  localparam logic [4:0] ALU_MVN   = 5'b01111;
  localparam logic [4:0] OP_BYPASS = 5'b10000;

  // TST/TEQ/CMP/CMN only set flags; they never write the register file
  function automatic logic is_compare(input logic [3:0] opc);
    return (opc[3:2] == 2'b10);
  endfunction

  function automatic logic [4:0] alu_op_decode(input logic [3:0] opc);
    return (opc == OPC_MOV) ? OP_BYPASS : {1'b0, opc};
  endfunction

endpackage

// File: rtl/arm_cond_check.sv
// Combinational ARM condition-code evaluator; shared with the branch unit.
module arm_cond_check
  import arm_dp_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;
  assign n = nzcv[3];
  assign z = nzcv[2];
  assign c = nzcv[1];
  assign v = nzcv[0];

  // Select the predicate named by the condition field
  always_comb begin
    pass = 1'b0;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_dp_sequencer.sv
// Multi-cycle sequencer for ARM data-processing instructions. Latches one
// instruction per handshake, evaluates its condition against the NZCV
// status register, then drives the ALU through EXEC and WB and updates the
// status register on flag-setting operations.
//
// Handshake: an instruction transfers on a rising edge where instr_valid
// and instr_ready are both high. instr_ready is high only in IDLE and does
// not depend on instr_valid; a valid held while busy is not consumed.
module arm_dp_sequencer
  import arm_dp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [4:0]  alu_op,
  output logic        alu_s,
  output logic        alu_out_en,
  output logic [3:0]  flags,
  input  logic [3:0]  flags_in,
  output logic [3:0]  rn_addr,
  output logic [3:0]  rd_addr,
  output logic [3:0]  rm_addr,
  output logic        op2_imm,
  output logic [11:0] shifter_op,
  output logic        rf_we,
  output logic        done,
  output logic        skipped,
  output logic        undef,
  output state_t      dbg_state
);

  state_t      state, state_nxt;
  logic [31:0] ir;
  logic        accept;
  logic        cond_pass;
  logic        ir_undef;
  logic        ir_compare;
  logic        ir_writes;

  assign accept     = instr_valid & instr_ready;
  assign ir_undef   = (ir[27:26] != 2'b00);
  assign ir_compare = is_compare(ir[24:21]);
  assign ir_writes  = ~ir_compare;

  // Datapath-facing fields come straight from the instruction register so
  // they stay stable from COND until the next accept
  assign alu_op     = alu_op_decode(ir[24:21]);
  assign alu_s      = ir_compare | ir[20];
  assign rn_addr    = ir[19:16];
  assign rd_addr    = ir[15:12];
  assign rm_addr    = ir[3:0];
  assign op2_imm    = ir[25];
  assign shifter_op = ir[11:0];
  assign dbg_state  = state;

  arm_cond_check u_cond_check (
    .cond (ir[31:28]),
    .nzcv (flags),
    .pass (cond_pass)
  );

  // Instruction register: captures the word on an accepted handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= '0;
    end else if (accept) begin
      ir <= instr;
    end
  end

  // Status register: updated when leaving WB on flag-setting operations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= '0;
    end else if ((state == ST_WB) && alu_s) begin
      flags <= flags_in;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    alu_out_en  = 1'b0;
    rf_we       = 1'b0;
    done        = 1'b0;
    skipped     = 1'b0;
    undef       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (accept) state_nxt = ST_COND;
      end
      ST_COND: begin
        // An undefined encoding is reported as UNDEF even if its
        // condition would also have failed
        if (ir_undef || !cond_pass) begin
          done      = 1'b1;
          undef     = ir_undef;
          skipped   = ~ir_undef;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_out_en = ir_writes;
        state_nxt  = ST_WB;
      end
      ST_WB: begin
        alu_out_en = ir_writes;
        rf_we      = ir_writes;
        done       = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_arm_dp_sequencer.sv
// Bench for arm_dp_sequencer: directed instructions followed by random
// ones, each compared cycle by cycle against a behavioural model.
module tb_arm_dp_sequencer;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  alu_op;
  logic        alu_s;
  logic        alu_out_en;
  logic [3:0]  flags;
  logic [3:0]  flags_in;
  logic [3:0]  rn_addr;
  logic [3:0]  rd_addr;
  logic [3:0]  rm_addr;
  logic        op2_imm;
  logic [11:0] shifter_op;
  logic        rf_we;
  logic        done;
  logic        skipped;
  logic        undef;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] model_flags;
  logic [3:0] exp_q[$];

  arm_dp_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_op      (alu_op),
    .alu_s       (alu_s),
    .alu_out_en  (alu_out_en),
    .flags       (flags),
    .flags_in    (flags_in),
    .rn_addr     (rn_addr),
    .rd_addr     (rd_addr),
    .rm_addr     (rm_addr),
    .op2_imm     (op2_imm),
    .shifter_op  (shifter_op),
    .rf_we       (rf_we),
    .done        (done),
    .skipped     (skipped),
    .undef       (undef),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference condition table on N,Z,C,V
  function automatic bit ref_cond(input logic [3:0] cc, input logic [3:0] f);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_fields(input string tag, input logic [31:0] iw,
                              input logic [4:0] e_op, input bit e_s);
    check({tag, "_alu_op"}, alu_op, e_op);
    check({tag, "_alu_s"}, alu_s, e_s);
    check({tag, "_rn"}, rn_addr, iw[19:16]);
    check({tag, "_rd"}, rd_addr, iw[15:12]);
    check({tag, "_rm"}, rm_addr, iw[3:0]);
    check({tag, "_imm"}, op2_imm, iw[25]);
    check({tag, "_shop"}, shifter_op, iw[11:0]);
  endtask

  // Driver + model: issue one instruction and follow it to completion.
  // With noisy set, instr_valid stays high with junk words while busy.
  task automatic run_instr(input logic [31:0] iw, input logic [3:0] fin, input bit noisy);
    int budget;
    logic [3:0] opc;
    bit is_und, is_pass, is_cmp, e_s;
    logic [4:0] e_op;
    budget = 0;
    while (!instr_ready && budget < 8) begin
      step();
      budget++;
    end
    check("ready_wait", instr_ready, 1'b1);
    opc     = iw[24:21];
    is_und  = (iw[27:26] != 2'b00);
    is_pass = ref_cond(iw[31:28], model_flags);
    is_cmp  = (opc >= 4'd8) && (opc <= 4'd11);
    e_op    = (opc == 4'd13) ? 5'd16 : {1'b0, opc};
    e_s     = is_cmp || iw[20];
    if (!is_und && is_pass && e_s) model_flags = fin;
    exp_q.push_back(model_flags);
    instr       = iw;
    instr_valid = 1'b1;
    flags_in    = fin;
    step();
    if (noisy) instr = $urandom;
    else instr_valid = 1'b0;
    check_fields("c1", iw, e_op, e_s);
    check("c1_ready", instr_ready, 1'b0);
    check("c1_out_en", alu_out_en, 1'b0);
    check("c1_rf_we", rf_we, 1'b0);
    if (is_und || !is_pass) begin
      check("c1_done", done, 1'b1);
      check("c1_undef", undef, is_und);
      check("c1_skipped", skipped, !is_und);
      step();
      instr_valid = 1'b0;
      check("c2_ready", instr_ready, 1'b1);
      check("c2_done", done, 1'b0);
      check("c2_flags", flags, exp_q.pop_front());
    end else begin
      check("c1_done", done, 1'b0);
      step();
      check("c2_out_en", alu_out_en, !is_cmp);
      check("c2_rf_we", rf_we, 1'b0);
      check("c2_done", done, 1'b0);
      step();
      check_fields("c3", iw, e_op, e_s);
      check("c3_out_en", alu_out_en, !is_cmp);
      check("c3_rf_we", rf_we, !is_cmp);
      check("c3_done", done, 1'b1);
      check("c3_skipped", skipped, 1'b0);
      check("c3_undef", undef, 1'b0);
      step();
      instr_valid = 1'b0;
      check("c4_ready", instr_ready, 1'b1);
      check("c4_done", done, 1'b0);
      check("c4_rf_we", rf_we, 1'b0);
      check("c4_flags", flags, exp_q.pop_front());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, instr_ready, 1'b1);
    check({tag, "_flags"}, flags, 4'h0);
    check({tag, "_strobes"}, {rf_we, alu_out_en, done, skipped, undef}, 5'b0);
    check({tag, "_alu"}, {alu_op, alu_s}, 6'b0);
    check({tag, "_fields"}, {rn_addr, rd_addr, rm_addr, op2_imm, shifter_op}, 25'b0);
  endtask

  initial begin
    logic [31:0] iw;
    rst_n       = 1'b0;
    instr       = '0;
    instr_valid = 1'b0;
    flags_in    = '0;
    model_flags = '0;
    repeat (3) step();
    check_reset_outputs("rst_hold");
    #2 rst_n = 1'b1;
    step();
    check_reset_outputs("rst_rel");

    // Directed sequence
    run_instr(32'h01A00001, 4'hF, 1'b0);  // MOVEQ, Z=0: skipped
    run_instr(32'hE0921003, 4'h6, 1'b0);  // ADDS R1,R2,R3
    check("adds_flags", flags, 4'h6);
    run_instr(32'hE3540000, 4'h4, 1'b1);  // CMP R4,#0
    check("cmp_flags", flags, 4'h4);
    run_instr(32'h01A00001, 4'hA, 1'b0);  // MOVEQ, Z=1: executes
    run_instr(32'hE5910000, 4'hF, 1'b0);  // LDR: undefined
    check("ldr_flags", flags, 4'h4);

    // Reset during EXEC aborts the instruction
    instr       = 32'hE0921003;
    instr_valid = 1'b1;
    flags_in    = 4'h6;
    step();
    instr_valid = 1'b0;
    step();
    check("abort_exec_out_en", alu_out_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("abort_rst");
    model_flags = 4'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_no_we", rf_we, 1'b0);
    end
    #2 rst_n = 1'b1;
    step();
    check_reset_outputs("abort_rel");
    run_instr(32'hE0921003, 4'h6, 1'b0);
    check("after_abort_flags", flags, 4'h6);

    // Random instructions
    for (int i = 0; i < 200; i++) begin
      iw = $urandom;
      if ($urandom_range(0, 7) != 0) iw[27:26] = 2'b00;
      if ($urandom_range(0, 3) == 0) iw[31:28] = 4'hE;
      run_instr(iw, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
